alu_acc: RTL and testbench
==========================

ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 a, b  input  WIDTH each  operands.
REQ-007 cin  input  1  carry-in for ADD.
REQ-008 op  input  3  opcode: 0 NOT, 1 ADD, 2 AND, 3 OR, 4 XOR, 5 ROTL, 6 MUL/ZERO, 7 ONES.
REQ-009 acc_sel  input  1  when 1, the internal result register replaces a as the first operand.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 cout  output  1  registered carry/overflow flag.
REQ-014 zero  output  1  registered flag, high when result is all zeros.

Function
REQ-015 FSM states IDLE, EXEC, DONE; a request is accepted on an edge where in_valid and in_ready are both high.
REQ-016 a, b, cin, op and acc_sel are captured at the accept edge; later changes have no effect on the operation in flight.
REQ-017 Single-cycle ops (0-4, 7, and 6 without the macro): IDLE to DONE on the accept edge; latency 1.
REQ-018 ADD: result = (A+B+cin) mod 2^WIDTH; cout = carry out of bit WIDTH-1.
REQ-019 NOT/AND/OR/XOR/ONES: bitwise results; ONES = all ones; cout = 0.
REQ-020 ROTL: k = b mod WIDTH; IDLE to EXEC, one-bit left rotation per EXEC edge; DONE after the k-th step; latency 1+k. k=0 goes straight to DONE with result = A; cout = 0.
REQ-021 DONE: out_valid=1; result, cout and zero are held stable until the edge where out_ready=1, which returns the FSM to IDLE.
REQ-022 No accept in EXEC or DONE, including the DONE-exit edge; in_ready rises on the cycle after that edge.
REQ-023 zero is updated together with result and always equals (result==0).
REQ-024 The result register persists across operations and is the A source for acc_sel=1.

Reset
REQ-025 When rst_n=0: FSM=IDLE, result=0, cout=0, zero=1, out_valid=0, in_ready=1, iteration counter=0.
REQ-026 An operation in flight when reset asserts is aborted and produces no out_valid.

Configuration
REQ-027 Macro ALU_ACC_MUL_EN.
REQ-028 Defined: op 6 is an iterative shift-add multiply taking one bit of B per EXEC edge, latency 1+WIDTH; result = low WIDTH bits of the product; cout = OR of the high WIDTH product bits.
REQ-029 Not defined: op 6 returns all zeros with cout=0 and latency 1, and no multiply logic is present.

Verification (WIDTH=8)
REQ-030 ADD a=0xF0, b=0x20, cin=1 -> result=0x11, cout=1, zero=0; out_valid 1 edge after accept.
REQ-031 ROTL a=0x81, b=3 -> result=0x0C; out_valid 4 edges after accept; in_ready=0 meanwhile. ROTL with b=8 -> result=0x81, latency 1.
REQ-032 XOR a=0x55, b=0xFF -> 0xAA; then NOT with acc_sel=1 and a=0x00 -> 0x55.
REQ-033 Hold out_ready=0 for 5 cycles after ADD -> result, cout, zero and out_valid are stable and in_ready=0; out_ready=1 -> IDLE, in_ready=1 on the next cycle.
REQ-034 op 6, a=0x0F, b=0x11: with macro -> result=0xFF, cout=0, latency 9; a=0x10, b=0x10 -> result=0x00, cout=1, zero=1. Without macro -> result=0x00, zero=1, latency 1.
REQ-035 Assert rst_n=0 on the 2nd EXEC cycle of ROTL b=5 -> out_valid=0, result=0, zero=1, in_ready=1 immediately, with no stale result after release.

Source files
------------

// File: rtl/alu_acc.sv
// alu_acc: small accumulator ALU with a valid/ready request side and a held
// result side. Bitwise ops, ADD and ONES finish on the accept edge. ROTL
// rotates one bit per EXEC cycle. The result register doubles as the
// accumulator operand.
// Optional build macro ALU_ACC_MUL_EN: op 6 becomes an iterative shift-add
// multiply. Without it, op 6 returns zero in one cycle.
module alu_acc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [2:0]       op,
   input  logic             acc_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero
);

   // The counter must hold WIDTH itself, which is the multiply step count.
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] wa;       // rotation working copy

   logic [WIDTH-1:0] opa;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sc_res;
   logic             sc_cout;
   logic [CW-1:0]    rk;
   logic [WIDTH-1:0] rot_nxt;

`ifdef ALU_ACC_MUL_EN
   logic                 mul_q;
   logic [2*WIDTH-1:0]   mc;       // multiplicand, shifted left each step
   logic [2*WIDTH-1:0]   prod;
   logic [2*WIDTH-1:0]   prod_nxt;
   logic [WIDTH-1:0]     wb;       // multiplier, consumed LSB first

   // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
   always_comb prod_nxt = wb[0] ? (prod + mc) : prod;
`endif

   // Operand select, single-cycle results, and the ROTL step count.
   always_comb begin
      opa     = acc_sel ? result : a;
      sum     = {1'b0, opa} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      sc_cout = 1'b0;
      case (op)
         3'd0:    sc_res = ~opa;
         3'd1:    begin sc_res = sum[WIDTH-1:0]; sc_cout = sum[WIDTH]; end
         3'd2:    sc_res = opa & b;
         3'd3:    sc_res = opa | b;
         3'd4:    sc_res = opa ^ b;
         3'd5:    sc_res = opa;          // ROTL by zero
         3'd7:    sc_res = '1;
         default: sc_res = '0;           // op 6 when the multiplier is absent
      endcase
      rk      = CW'(32'(b) % WIDTH);
      rot_nxt = {wa[WIDTH-2:0], wa[WIDTH-1]};
   end

   // Control FSM with registered handshake outputs and the result/flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         wa        <= '0;
         result    <= '0;
         cout      <= 1'b0;
         zero      <= 1'b1;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
`ifdef ALU_ACC_MUL_EN
         mul_q     <= 1'b0;
         mc        <= '0;
         prod      <= '0;
         wb        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  if (op == 3'd5 && rk != '0) begin
                     wa    <= opa;
                     cnt   <= rk;
                     state <= EXEC;
`ifdef ALU_ACC_MUL_EN
                     mul_q <= 1'b0;
`endif
                  end
`ifdef ALU_ACC_MUL_EN
                  else if (op == 3'd6) begin
                     mc    <= {{WIDTH{1'b0}}, opa};
                     wb    <= b;
                     prod  <= '0;
                     cnt   <= CW'(WIDTH);
                     mul_q <= 1'b1;
                     state <= EXEC;
                  end
`endif
                  else begin
                     result    <= sc_res;
                     cout      <= sc_cout;
                     zero      <= (sc_res == '0);
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            EXEC: begin
               cnt <= cnt - CW'(1);
`ifdef ALU_ACC_MUL_EN
               if (mul_q) begin
                  prod <= prod_nxt;
                  mc   <= mc << 1;
                  wb   <= wb >> 1;
                  if (cnt == CW'(1)) begin
                     result    <= prod_nxt[WIDTH-1:0];
                     cout      <= |prod_nxt[2*WIDTH-1:WIDTH];
                     zero      <= (prod_nxt[WIDTH-1:0] == '0);
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end else
`endif
               begin
                  wa <= rot_nxt;
                  if (cnt == CW'(1)) begin
                     result    <= rot_nxt;
                     cout      <= 1'b0;
                     zero      <= (rot_nxt == '0);
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               // The exit edge never accepts; in_ready is seen one cycle later.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_acc.sv
// tb_alu_acc: directed scoreboard bench for alu_acc at WIDTH=8.
module tb_alu_acc;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic [2:0] op = '0;
   logic       acc_sel = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic       cout;
   logic       zero;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] res;
      logic       c;
      logic       z;
      int         lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   alu_acc #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op        (op),
      .acc_sel   (acc_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .zero      (zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Issue one request, scramble inputs after the accept edge, wait for the
   // result, compare against the scoreboard, optionally hold, then release.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] ia,
                         input logic [7:0] ib, input logic ic, input logic as,
                         input logic [7:0] er, input logic ec, input logic ez,
                         input int elat, input int hold);
      exp_t e;
      int   lat;
      @(negedge clk);
      chk({tag, "/in_ready_idle"}, in_ready, 1);
      op = o; a = ia; b = ib; cin = ic; acc_sel = as; in_valid = 1'b1;
      sb.push_back('{er, ec, ez, elat});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      acc_sel = 1'($urandom); op = 3'($urandom);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         chk({tag, "/busy_in_ready"}, in_ready, 0);
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      chk({tag, "/out_valid"}, out_valid, 1);
      chk({tag, "/result"}, result, e.res);
      chk({tag, "/cout"}, cout, e.c);
      chk({tag, "/zero"}, zero, e.z);
      chk({tag, "/latency"}, lat, e.lat);
      chk({tag, "/done_in_ready"}, in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "/hold_valid"}, out_valid, 1);
         chk({tag, "/hold_result"}, result, e.res);
         chk({tag, "/hold_cout"}, cout, e.c);
         chk({tag, "/hold_zero"}, zero, e.z);
         chk({tag, "/hold_in_ready"}, in_ready, 0);
      end
      // A request offered on the exit edge must not be taken.
      out_ready = 1'b1; in_valid = 1'b1; op = 3'd7; acc_sel = 1'b0;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      chk({tag, "/released_valid"}, out_valid, 0);
      chk({tag, "/released_in_ready"}, in_ready, 1);
      chk({tag, "/released_result"}, result, e.res);
   endtask

   initial begin
      #12;
      chk("reset/in_ready", in_ready, 1);
      chk("reset/out_valid", out_valid, 0);
      chk("reset/result", result, 8'h00);
      chk("reset/cout", cout, 0);
      chk("reset/zero", zero, 1);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_hold", 3'd1, 8'hF0, 8'h20, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1, 5);
      run_op("rotl3",    3'd5, 8'h81, 8'h03, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0, 4, 0);
      run_op("rotl8",    3'd5, 8'h81, 8'h08, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1, 0);
      run_op("xor",      3'd4, 8'h55, 8'hFF, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1, 0);
      run_op("not_acc",  3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1, 0);
      run_op("and",      3'd2, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1, 0);
      run_op("or_acc",   3'd3, 8'h00, 8'h0F, 1'b0, 1'b1, 8'h3F, 1'b0, 1'b0, 1, 0);
      run_op("ones",     3'd7, 8'h12, 8'h34, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1, 0);
      run_op("add_wrap", 3'd1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1, 0);
`ifdef ALU_ACC_MUL_EN
      run_op("mul_a",    3'd6, 8'h0F, 8'h11, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 9, 0);
      run_op("mul_b",    3'd6, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 9, 0);
`else
      run_op("op6_a",    3'd6, 8'h0F, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1, 0);
      run_op("op6_b",    3'd6, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1, 0);
`endif
      run_op("rotl11",   3'd5, 8'h01, 8'h0B, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 4, 0);

      // Abort a ROTL by 5 during its second EXEC cycle.
      @(negedge clk);
      op = 3'd5; a = 8'h81; b = 8'h05; cin = 1'b0; acc_sel = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 chk("abort/in_flight", in_ready, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("abort/out_valid", out_valid, 0);
      chk("abort/result", result, 8'h00);
      chk("abort/zero", zero, 1);
      chk("abort/cout", cout, 0);
      chk("abort/in_ready", in_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort/no_stale_valid", out_valid, 0);
      end
      chk("abort/result_after", result, 8'h00);

      // Accumulator restarts from zero after reset.
      run_op("acc_post_rst", 3'd1, 8'hAA, 8'h05, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1, 0);

      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
